// File: rtl/flux_gpu_pkg.sv
// Shared types and constants for the shader-core operand collector.
package flux_gpu_pkg;

    localparam int REG_ADDR_W       = 5;
    localparam int NUM_THREADS_DEF  = 32;
    localparam int DATA_WIDTH_DEF   = 128;

    // Thread-id width for a given thread count.
    function automatic int tid_width(input int num_threads);
        return $clog2(num_threads);
    endfunction

    localparam int TID_W = tid_width(NUM_THREADS_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ1 = 2'd1,
        READ2 = 2'd2,
        OUT   = 2'd3
    } collector_state_e;

endpackage

// File: rtl/operand_collector_bypass.sv
// Per-port operand select: zero register, same-cycle writeback, or register file data.
module operand_bypass
    import flux_gpu_pkg::*;
#(
    parameter int TID_W      = 5,
    parameter int DATA_WIDTH = 128
) (
    input  logic [TID_W-1:0]      rd_thread_id,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rf_data,
    input  logic                  wb_valid,
    input  logic [TID_W-1:0]      wb_thread_id,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic [DATA_WIDTH-1:0] rd_data
);

    // Register 0 reads as zero; a matching writeback lands this edge, so forward it.
    always_comb begin
        rd_data = {DATA_WIDTH{1'b0}};
        if (rd_addr == {REG_ADDR_W{1'b0}}) begin
            rd_data = {DATA_WIDTH{1'b0}};
        end else if (wb_valid && (wb_thread_id == rd_thread_id) && (wb_addr == rd_addr)) begin
            rd_data = wb_data;
        end else begin
            rd_data = rf_data;
        end
    end

endmodule

// File: rtl/operand_collector.sv
// Operand collector: fetches up to three source operands over two register file
// read ports and hands the bundle to the execution stage.
module operand_collector
    import flux_gpu_pkg::*;
#(
    parameter int NUM_THREADS = 32,
    parameter int NUM_REGS    = 32,
    parameter int DATA_WIDTH  = 128,
    parameter int OPC_W       = 8,
    localparam int TID_W      = tid_width(NUM_THREADS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [TID_W-1:0]      issue_thread_id,
    input  logic [REG_ADDR_W-1:0] issue_src_a,
    input  logic [REG_ADDR_W-1:0] issue_src_b,
    input  logic [REG_ADDR_W-1:0] issue_src_c,
    input  logic [1:0]            issue_num_srcs,
    input  logic [REG_ADDR_W-1:0] issue_dst,
    input  logic [OPC_W-1:0]      issue_opcode,
    output logic [TID_W-1:0]      rf_rd_thread_id_a,
    output logic [TID_W-1:0]      rf_rd_thread_id_b,
    output logic [REG_ADDR_W-1:0] rf_rd_addr_a,
    output logic [REG_ADDR_W-1:0] rf_rd_addr_b,
    input  logic [DATA_WIDTH-1:0] rf_rd_data_a,
    input  logic [DATA_WIDTH-1:0] rf_rd_data_b,
    input  logic                  wb_valid,
    input  logic [TID_W-1:0]      wb_thread_id,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  op_valid,
    input  logic                  op_ready,
    output logic [TID_W-1:0]      op_thread_id,
    output logic [REG_ADDR_W-1:0] op_dst,
    output logic [OPC_W-1:0]      op_opcode,
    output logic [DATA_WIDTH-1:0] op_a,
    output logic [DATA_WIDTH-1:0] op_b,
    output logic [DATA_WIDTH-1:0] op_c
);

    // The register address width is fixed; a mismatched register count is a build error.
    if (NUM_REGS != (1 << REG_ADDR_W)) begin : g_bad_num_regs
        $error("operand_collector: NUM_REGS must equal 2**REG_ADDR_W");
    end

    collector_state_e        state_r, next_state_s;
    logic                    issue_ready_s, accept_s;
    logic [TID_W-1:0]        tid_r;
    logic [REG_ADDR_W-1:0]   src_c_r, dst_r;
    logic [1:0]              num_srcs_r;
    logic [OPC_W-1:0]        opcode_r;
    logic [TID_W-1:0]        rd_tid_nxt_s, rd_tid_r;
    logic [REG_ADDR_W-1:0]   rd_addr_a_nxt_s, rd_addr_b_nxt_s, rd_addr_a_r, rd_addr_b_r;
    logic [DATA_WIDTH-1:0]   byp_a_s, byp_b_s;
    logic                    op_valid_r;
    logic [TID_W-1:0]        op_thread_id_r;
    logic [REG_ADDR_W-1:0]   op_dst_r;
    logic [OPC_W-1:0]        op_opcode_r;
    logic [DATA_WIDTH-1:0]   op_a_r, op_b_r, op_c_r;

    // Accept handshake; issue_ready may follow op_ready combinationally.
    always_comb begin
        issue_ready_s = 1'b0;
        if (rst) begin
            issue_ready_s = 1'b0;
        end else begin
            issue_ready_s = (state_r == IDLE) || ((state_r == OUT) && op_ready);
        end
        accept_s = issue_valid && issue_ready_s;
    end

    // Next-state decode for the collection sequence.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE:  next_state_s = accept_s ? READ1 : IDLE;
            READ1: next_state_s = (num_srcs_r == 2'd3) ? READ2 : OUT;
            READ2: next_state_s = OUT;
            OUT: begin
                if (op_ready) begin
                    next_state_s = accept_s ? READ1 : IDLE;
                end else begin
                    next_state_s = OUT;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Read-port request for the coming state; unused sources read register 0.
    always_comb begin
        rd_tid_nxt_s    = {TID_W{1'b0}};
        rd_addr_a_nxt_s = {REG_ADDR_W{1'b0}};
        rd_addr_b_nxt_s = {REG_ADDR_W{1'b0}};
        case (next_state_s)
            READ1: begin
                rd_tid_nxt_s    = issue_thread_id;
                rd_addr_a_nxt_s = (issue_num_srcs >= 2'd1) ? issue_src_a : {REG_ADDR_W{1'b0}};
                rd_addr_b_nxt_s = (issue_num_srcs >= 2'd2) ? issue_src_b : {REG_ADDR_W{1'b0}};
            end
            READ2: begin
                rd_tid_nxt_s    = tid_r;
                rd_addr_a_nxt_s = src_c_r;
            end
            default: begin
                rd_tid_nxt_s    = {TID_W{1'b0}};
            end
        endcase
    end

    operand_bypass #(.TID_W(TID_W), .DATA_WIDTH(DATA_WIDTH)) u_bypass_a (
        .rd_thread_id (rd_tid_r),
        .rd_addr      (rd_addr_a_r),
        .rf_data      (rf_rd_data_a),
        .wb_valid     (wb_valid),
        .wb_thread_id (wb_thread_id),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .rd_data      (byp_a_s)
    );

    operand_bypass #(.TID_W(TID_W), .DATA_WIDTH(DATA_WIDTH)) u_bypass_b (
        .rd_thread_id (rd_tid_r),
        .rd_addr      (rd_addr_b_r),
        .rf_data      (rf_rd_data_b),
        .wb_valid     (wb_valid),
        .wb_thread_id (wb_thread_id),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .rd_data      (byp_b_s)
    );

    // State register and registered read-port requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            rd_tid_r    <= {TID_W{1'b0}};
            rd_addr_a_r <= {REG_ADDR_W{1'b0}};
            rd_addr_b_r <= {REG_ADDR_W{1'b0}};
        end else begin
            state_r     <= next_state_s;
            rd_tid_r    <= rd_tid_nxt_s;
            rd_addr_a_r <= rd_addr_a_nxt_s;
            rd_addr_b_r <= rd_addr_b_nxt_s;
        end
    end

    // Capture the instruction fields still needed after the accept edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tid_r      <= {TID_W{1'b0}};
            src_c_r    <= {REG_ADDR_W{1'b0}};
            num_srcs_r <= 2'd0;
            dst_r      <= {REG_ADDR_W{1'b0}};
            opcode_r   <= {OPC_W{1'b0}};
        end else if (accept_s) begin
            tid_r      <= issue_thread_id;
            src_c_r    <= (issue_num_srcs == 2'd3) ? issue_src_c : {REG_ADDR_W{1'b0}};
            num_srcs_r <= issue_num_srcs;
            dst_r      <= issue_dst;
            opcode_r   <= issue_opcode;
        end
    end

    // Operand bundle registers; only the read states write them, so OUT holds stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_valid_r     <= 1'b0;
            op_thread_id_r <= {TID_W{1'b0}};
            op_dst_r       <= {REG_ADDR_W{1'b0}};
            op_opcode_r    <= {OPC_W{1'b0}};
            op_a_r         <= {DATA_WIDTH{1'b0}};
            op_b_r         <= {DATA_WIDTH{1'b0}};
            op_c_r         <= {DATA_WIDTH{1'b0}};
        end else begin
            op_valid_r <= (next_state_s == OUT);
            case (state_r)
                READ1: begin
                    op_a_r         <= byp_a_s;
                    op_b_r         <= byp_b_s;
                    op_c_r         <= {DATA_WIDTH{1'b0}};
                    op_thread_id_r <= tid_r;
                    op_dst_r       <= dst_r;
                    op_opcode_r    <= opcode_r;
                end
                READ2: begin
                    op_c_r <= byp_a_s;
                end
                default: begin
                    op_c_r <= op_c_r;
                end
            endcase
        end
    end

    assign issue_ready       = issue_ready_s;
    assign rf_rd_thread_id_a = rd_tid_r;
    assign rf_rd_thread_id_b = rd_tid_r;
    assign rf_rd_addr_a      = rd_addr_a_r;
    assign rf_rd_addr_b      = rd_addr_b_r;
    assign op_valid          = op_valid_r;
    assign op_thread_id      = op_thread_id_r;
    assign op_dst            = op_dst_r;
    assign op_opcode         = op_opcode_r;
    assign op_a              = op_a_r;
    assign op_b              = op_b_r;
    assign op_c              = op_c_r;

endmodule
